// File: rtl/comparator_2bit.sv
// 2-bit magnitude comparator with selectable unsigned/two's-complement operands.
// One-cycle registered result; flags hold between captures, out_valid pulses per capture.
module comparator_2bit (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       in_valid,
    input  logic       signed_mode,
    input  logic [1:0] A,
    input  logic [1:0] B,
    output logic       A_gt_B,
    output logic       A_lt_B,
    output logic       A_eq_B,
    output logic       out_valid
);

    typedef struct packed {
        logic gt;
        logic lt;
        logic eq;
    } cmp_res_t;

    cmp_res_t   res_d, res_q;
    logic [1:0] a_key, b_key;

    // Flipping the sign bit maps two's complement -2..1 onto 0..3 in order,
    // so one unsigned compare serves both modes.
    always_comb begin
        a_key  = {A[1] ^ signed_mode, A[0]};
        b_key  = {B[1] ^ signed_mode, B[0]};
        res_d  = '0;
        res_d.eq = (A == B);
        res_d.gt = (a_key > b_key);
        res_d.lt = (a_key < b_key);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_q     <= '0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid)
                res_q <= res_d;
        end
    end

    assign A_gt_B = res_q.gt;
    assign A_lt_B = res_q.lt;
    assign A_eq_B = res_q.eq;

endmodule

// File: tb/tb_comparator_2bit.sv
// Directed bench for comparator_2bit: exhaustive unsigned/signed tables, hold,
// async reset, reset release and a randomized one-hot / out_valid sweep.
module tb_comparator_2bit;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       signed_mode;
    logic [1:0] A, B;
    logic       A_gt_B, A_lt_B, A_eq_B, out_valid;

    int n_assert = 0;
    int n_fail   = 0;

    localparam logic [2:0] GT = 3'b100, LT = 3'b010, EQ = 3'b001;

    // Hand-computed expected {gt,lt,eq} for {A,B} = 0..15
    logic [2:0] exp_u [16] = '{EQ, LT, LT, LT,  GT, EQ, LT, LT,  GT, GT, EQ, LT,  GT, GT, GT, EQ};
    logic [2:0] exp_s [16] = '{EQ, LT, GT, GT,  GT, EQ, GT, GT,  LT, LT, EQ, LT,  LT, LT, GT, EQ};

    comparator_2bit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .signed_mode(signed_mode),
        .A          (A),
        .B          (B),
        .A_gt_B     (A_gt_B),
        .A_lt_B     (A_lt_B),
        .A_eq_B     (A_eq_B),
        .out_valid  (out_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    function automatic logic [3:0] outs();
        return {A_gt_B, A_lt_B, A_eq_B, out_valid};
    endfunction

    initial begin
        logic [3:0] ab;
        logic       prev_vld;

        rst_n = 1'b0; in_valid = 1'b1; signed_mode = 1'b0; A = 2'b11; B = 2'b00;
        #1;
        check("reset_async_t0", outs(), 4'b0000);
        // in_valid high across edges while reset is held must be ignored
        @(negedge clk); @(negedge clk);
        check("reset_held_edge", outs(), 4'b0000);

        in_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_idle", outs(), 4'b0000);

        // Exhaustive unsigned, back-to-back
        in_valid = 1'b1; signed_mode = 1'b0;
        for (int i = 0; i < 16; i++) begin
            ab = i[3:0];
            A = ab[3:2]; B = ab[1:0];
            @(negedge clk);
            check($sformatf("unsigned_%0d", i), outs(), {exp_u[i], 1'b1});
        end

        // Exhaustive signed, back-to-back
        signed_mode = 1'b1;
        for (int i = 0; i < 16; i++) begin
            ab = i[3:0];
            A = ab[3:2]; B = ab[1:0];
            @(negedge clk);
            check($sformatf("signed_%0d", i), outs(), {exp_s[i], 1'b1});
        end

        // Hold: capture 11 vs 00 unsigned (gt), then idle with toggling inputs
        signed_mode = 1'b0; A = 2'b11; B = 2'b00;
        @(negedge clk);
        check("hold_capture", outs(), 4'b1001);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            A = ~A; B = ~B; signed_mode = ~signed_mode;
            @(negedge clk);
            check($sformatf("hold_%0d", i), outs(), 4'b1000);
        end

        // Async reset between edges while A_eq_B is set
        in_valid = 1'b1; signed_mode = 1'b0; A = 2'b10; B = 2'b10;
        @(negedge clk);
        check("eq_before_reset", outs(), 4'b0011);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("async_reset", outs(), 4'b0000);

        // Reset release then a normal capture one cycle later
        @(negedge clk);
        rst_n = 1'b1;
        in_valid = 1'b1; A = 2'b01; B = 2'b01;
        #1;
        check("release_pre", outs(), 4'b0000);
        @(negedge clk);
        check("release_eq", outs(), 4'b0011);

        // Randomized stimulus with gaps: one-hot flags and out_valid tracking
        prev_vld = in_valid;
        for (int i = 0; i < 300; i++) begin
            in_valid    = ($urandom_range(0, 2) != 0);
            signed_mode = $urandom_range(0, 1);
            A           = $urandom_range(0, 3);
            B           = $urandom_range(0, 3);
            prev_vld    = in_valid;
            @(negedge clk);
            check("rand_out_valid", {3'b000, out_valid}, {3'b000, prev_vld});
            if (out_valid)
                check("rand_onehot", {3'b000, $onehot({A_gt_B, A_lt_B, A_eq_B})}, 4'b0001);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
